// File: rtl/shift_pkg.sv
// shift_pkg: constants and types shared by the shift engine and the main
// control FSM that launches it.
//   DEF_WIDTH / DEF_AMT_W : default data and shift-amount widths
//   OP_SLL / OP_SRL / OP_SRA : sh_op encodings
//   state_t : shift engine FSM state encoding
package shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shifter.
//   acc      in  WIDTH  current working value
//   op       in  3      sh_op encoding (OP_SLL / OP_SRL / OP_SRA)
//   acc_next out WIDTH  value after one shift step (acc unchanged for other ops)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    case (op)
      OP_SLL:  acc_next = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter, one bit per clock.
//   clk      in  1      system clock, rising edge
//   reset_n  in  1      asynchronous active-low reset
//   start    in  1      request, sampled only in IDLE
//   sh_op    in  3      SLL / SRL / SRA encoding
//   amt_src  in  1      0 = shamt, 1 = rs_amt
//   shamt    in  AMT_W  immediate shift amount
//   rs_amt   in  AMT_W  register shift amount
//   data_in  in  WIDTH  operand
//   busy     out 1      high in SHIFT and DONE
//   done     out 1      one-cycle completion pulse
//   err      out 1      illegal sh_op, coincident with done
//   result   out WIDTH  shifted value, held until the next accept
//
// state    | meaning
// ST_IDLE  | waiting for start; result holds the last value
// ST_SHIFT | one shift step per clock, cnt counts down to 0
// ST_DONE  | done (and err if flagged) for one cycle, then IDLE
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       sh_op,
  input  logic             amt_src,
  input  logic [AMT_W-1:0] shamt,
  input  logic [AMT_W-1:0] rs_amt,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  state_t           state, state_next;
  logic [2:0]       op;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_sel;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic             err_flag;
  logic             accept;

  assign amt_sel = amt_src ? rs_amt : shamt;
  assign accept  = (state == ST_IDLE) && start;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .op       (op),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // illegal ops and zero amounts skip SHIFT entirely
          if (!op_legal(sh_op) || (amt_sel == '0)) state_next = ST_DONE;
          else                                     state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == AMT_W'(1)) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op       <= '0;
      cnt      <= '0;
      acc      <= '0;
      err_flag <= 1'b0;
    end else if (accept) begin
      op       <= sh_op;
      cnt      <= amt_sel;
      err_flag <= !op_legal(sh_op);
      acc      <= op_legal(sh_op) ? data_in : '0;
    end else if (state == ST_SHIFT) begin
      acc <= acc_step;
      cnt <= cnt - AMT_W'(1);
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign err    = (state == ST_DONE) && err_flag;
  assign result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  sh_op = '0;
  logic        amt_src = 1'b0;
  logic [4:0]  shamt = '0;
  logic [4:0]  rs_amt = '0;
  logic [31:0] data_in = '0;
  logic        busy, done, err;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sh_op   (sh_op),
    .amt_src (amt_src),
    .shamt   (shamt),
    .rs_amt  (rs_amt),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Reference: whole-value arithmetic shift by n; illegal op gives 0.
  function automatic logic [31:0] model(input logic [2:0] op, input int n, input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    case (op)
      3'b010:  return d << n;
      3'b011:  return d >> n;
      3'b100:  return 32'(s >>> n);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
  endfunction

  task automatic scramble_inputs();
    sh_op   = 3'($urandom);
    amt_src = 1'($urandom);
    shamt   = 5'($urandom);
    rs_amt  = 5'($urandom);
    data_in = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic src, input logic [4:0] sa,
                        input logic [4:0] ra, input logic [31:0] d, input string name);
    logic [31:0] exp_r;
    bit          exp_e;
    int          n, got;
    bit          seen;
    n     = src ? int'(ra) : int'(sa);
    exp_e = !is_legal(op);
    exp_r = model(op, n, d);
    if (exp_e) n = 0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_before: busy=%b want 0", name, busy);
    end
    start = 1'b1; sh_op = op; amt_src = src; shamt = sa; rs_amt = ra; data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    seen = 0; got = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1; got = c;
      end else begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy_during: cycle %0d busy=%b want 1", name, c, busy);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: no done within 40 cycles, want cycle %0d", name, n + 1);
    end else begin
      if (got != n + 1) begin
        miscompares++;
        $display("FAIL %s latency: done at cycle %0d want %0d", name, got, n + 1);
      end
      vectors++;
      if (result !== exp_r || err !== exp_e || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s done_cycle: result=%h err=%b busy=%b want %h %b 1",
                 name, result, err, busy, exp_r, exp_e);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || result !== exp_r) begin
        miscompares++;
        $display("FAIL %s after_done: done=%b busy=%b err=%b result=%h want 0 0 0 %h",
                 name, done, busy, err, result, exp_r);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b err=%b result=%h want all 0", busy, done, err, result);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'b010, 1'b0, 5'd4,  5'd0,  32'h0000_0001, "sll4");
    run_op(3'b100, 1'b1, 5'd0,  5'd31, 32'h8000_0000, "sra31_rs");
    run_op(3'b011, 1'b0, 5'd31, 5'd2,  32'h8000_0000, "srl31");
    run_op(3'b100, 1'b1, 5'd9,  5'd4,  32'h7FFF_FFF0, "sra4");
    run_op(3'b010, 1'b0, 5'd0,  5'd17, 32'hDEAD_BEEF, "amt0");
    run_op(3'b000, 1'b0, 5'd5,  5'd5,  32'hDEAD_BEEF, "illegal");
    run_op(3'b111, 1'b1, 5'd0,  5'd0,  32'hFFFF_FFFF, "illegal7");
  endtask

  task automatic test_random();
    logic [2:0] ops [4];
    for (int i = 0; i < 40; i++) begin
      ops[0] = 3'b010; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'($urandom);
      run_op(ops[$urandom_range(0, 3)], 1'($urandom), 5'($urandom), 5'($urandom), $urandom, "random");
    end
  endtask

  // start held high: DONE at cycle 9, one IDLE cycle (10), re-accept, second DONE at 19
  task automatic test_back_to_back();
    bit exp_busy, exp_done;
    @(negedge clk);
    start = 1'b1; sh_op = 3'b010; amt_src = 1'b0; shamt = 5'd8; rs_amt = 5'd3;
    data_in = 32'h0000_00A5;
    @(posedge clk);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      exp_busy = (c != 10) && (c <= 19);
      exp_done = (c == 9) || (c == 19);
      vectors++;
      if (busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: busy=%b done=%b want %b %b", c, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        vectors++;
        if (result !== 32'h0000_A500) begin
          miscompares++;
          $display("FAIL b2b result cycle %0d: %h want 0000a500", c, result);
        end
      end
      if (c == 11) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; sh_op = 3'b010; amt_src = 1'b0; shamt = 5'd20; data_in = 32'h1234_5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b err=%b result=%h want all 0", busy, done, err, result);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 4) reset_n = 1'b1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_abort cycle %0d: done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    run_op(3'b010, 1'b0, 5'd1, 5'd0, 32'h0000_0003, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
